decode_hazard_stage: RTL and testbench

DECODE_HAZARD_STAGE -- requirements
Module: decode_hazard_stage

---
 rtl/decode_hazard_stage.sv | 156 +++++++++++++++
 tb/tb_decode_hazard_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_stage.sv
// Decode stage with register file, load-use scoreboard and a one-entry output register.
// Optional feature: define DECODE_WB_BYPASS_EN to forward same-cycle write-back data and pending clears.
module decode_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [ADDR_W-1:0] in_addr_a,
    input  logic [ADDR_W-1:0] in_addr_b,
    input  logic [ADDR_W-1:0] in_addr_d,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_imm_sext,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic              in_is_branch,
    input  logic              in_is_imm,
    input  logic [1:0]        in_alu_op,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_is_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [ADDR_W-1:0] out_addr_a,
    output logic [ADDR_W-1:0] out_addr_b,
    output logic [ADDR_W-1:0] out_addr_d,
    output logic [1:0]        out_alu_op,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic              out_is_branch,
    output logic              out_is_imm,
    output logic [15:0]       stall_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  set_mask;
    logic [DEPTH-1:0]  clear_mask;
    logic [DEPTH-1:0]  visible_pending;
    logic [DATA_W-1:0] read_a;
    logic [DATA_W-1:0] read_b;
    logic [DATA_W-1:0] imm_ext;
    logic              wb_write;
    logic              wb_clear;
    logic              load_xfer;
    logic              load_in_out;
    logic              hz_a;
    logic              hz_b;
    logic              hazard;
    logic              accept;

    assign wb_write    = wb_en && (wb_addr != '0);
    assign wb_clear    = wb_write && wb_is_load;
    assign load_in_out = out_valid && out_mem_r_en;
    assign load_xfer   = out_valid && out_ready && !flush && out_mem_r_en && out_wb_en
                         && (out_addr_d != '0);
    assign set_mask    = load_xfer ? (DEPTH'(1) << out_addr_d) : '0;
    assign clear_mask  = wb_clear ? (DEPTH'(1) << wb_addr) : '0;

    always_comb begin
        read_a          = (in_addr_a == '0) ? '0 : regs[in_addr_a];
        read_b          = (in_addr_b == '0) ? '0 : regs[in_addr_b];
        visible_pending = pending;
`ifdef DECODE_WB_BYPASS_EN
        // A load write-back landing this cycle resolves its own hazard immediately.
        visible_pending = pending & ~clear_mask;
        if (wb_write && (wb_addr == in_addr_a) && (in_addr_a != '0)) read_a = wb_data;
        if (wb_write && (wb_addr == in_addr_b) && (in_addr_b != '0)) read_b = wb_data;
`endif
        hz_a = (in_addr_a != '0) &&
               (visible_pending[in_addr_a] || (load_in_out && (out_addr_d == in_addr_a)));
        hz_b = (in_addr_b != '0) &&
               (visible_pending[in_addr_b] || (load_in_out && (out_addr_d == in_addr_b)));
    end

    assign hazard   = in_valid && (hz_a || hz_b);
    assign in_ready = reset && (flush || (!hazard && (!out_valid || out_ready)));
    assign accept   = in_valid && in_ready && !flush;
    assign imm_ext  = in_imm_sext ? DATA_W'($signed(in_imm)) : DATA_W'(in_imm);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Set is applied after clear so a same-cycle set on the same register wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= (pending & ~clear_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_data_a    <= '0;
            out_data_b    <= '0;
            out_imm       <= '0;
            out_addr_a    <= '0;
            out_addr_b    <= '0;
            out_addr_d    <= '0;
            out_alu_op    <= '0;
            out_wb_en     <= 1'b0;
            out_mem_r_en  <= 1'b0;
            out_mem_w_en  <= 1'b0;
            out_is_branch <= 1'b0;
            out_is_imm    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_data_a    <= read_a;
            out_data_b    <= read_b;
            out_imm       <= imm_ext;
            out_addr_a    <= in_addr_a;
            out_addr_b    <= in_addr_b;
            out_addr_d    <= in_addr_d;
            out_alu_op    <= in_alu_op;
            out_wb_en     <= in_wb_en;
            out_mem_r_en  <= in_mem_r_en;
            out_mem_w_en  <= in_mem_w_en;
            out_is_branch <= in_is_branch;
            out_is_imm    <= in_is_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Self-checking bench for decode_hazard_stage: directed scenarios plus randomized traffic
// compared against an array-based reference model of the decode rules.
module tb_decode_hazard_stage;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_addr_a, in_addr_b, in_addr_d;
    logic [15:0] in_imm;
    logic        in_imm_sext, in_wb_en, in_mem_r_en, in_mem_w_en, in_is_branch, in_is_imm;
    logic [1:0]  in_alu_op;
    logic        flush, wb_en, wb_is_load;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_data_a, out_data_b, out_imm;
    logic [4:0]  out_addr_a, out_addr_b, out_addr_d;
    logic [1:0]  out_alu_op;
    logic        out_wb_en, out_mem_r_en, out_mem_w_en, out_is_branch, out_is_imm;
    logic [15:0] stall_cnt;

    int checks = 0;
    int passes = 0;

    decode_hazard_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_addr_a(in_addr_a), .in_addr_b(in_addr_b), .in_addr_d(in_addr_d),
        .in_imm(in_imm), .in_imm_sext(in_imm_sext), .in_wb_en(in_wb_en),
        .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en), .in_is_branch(in_is_branch),
        .in_is_imm(in_is_imm), .in_alu_op(in_alu_op), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_is_load(wb_is_load),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_data_a(out_data_a), .out_data_b(out_data_b), .out_imm(out_imm),
        .out_addr_a(out_addr_a), .out_addr_b(out_addr_b), .out_addr_d(out_addr_d),
        .out_alu_op(out_alu_op), .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
        .out_mem_w_en(out_mem_w_en), .out_is_branch(out_is_branch), .out_is_imm(out_is_imm),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, da, db, imm;
        logic [4:0]  aa, ab, ad;
        logic [1:0]  op;
        logic        wb, mr, mw, br, ii;
    } out_t;

    out_t        m_out;
    bit          m_ov;
    logic [31:0] m_rf [32];
    bit [31:0]   m_pend;
    int          m_stall;

    task automatic m_reset();
        m_out   = '0;
        m_ov    = 0;
        m_pend  = '0;
        m_stall = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    function automatic bit m_src_hz(input logic [4:0] a);
        bit cleared;
        cleared = BYP && wb_en && wb_is_load && (wb_addr == a);
        if (a == 5'd0) return 1'b0;
        return (m_pend[a] && !cleared) || (m_ov && m_out.mr && (m_out.ad == a));
    endfunction

    function automatic bit m_hazard();
        return in_valid && (m_src_hz(in_addr_a) || m_src_hz(in_addr_b));
    endfunction

    function automatic bit m_ready();
        return reset && (flush || (!m_hazard() && (!m_ov || out_ready)));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && wb_en && (wb_addr == a)) return wb_data;
        return m_rf[a];
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit   acc, haz, xfer;
        out_t n;
        haz  = m_hazard();
        acc  = in_valid && m_ready() && !flush;
        xfer = m_ov && out_ready && !flush && m_out.mr && m_out.wb && (m_out.ad != 5'd0);
        n.pc = in_pc;  n.da = m_read(in_addr_a);  n.db = m_read(in_addr_b);
        n.imm = (in_imm_sext && in_imm[15]) ? (32'hFFFF0000 | {16'h0, in_imm}) : {16'h0, in_imm};
        n.aa = in_addr_a;  n.ab = in_addr_b;  n.ad = in_addr_d;  n.op = in_alu_op;
        n.wb = in_wb_en;  n.mr = in_mem_r_en;  n.mw = in_mem_w_en;
        n.br = in_is_branch;  n.ii = in_is_imm;
        if (haz && !flush && m_stall < 65535) m_stall++;
        if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        if (wb_en && wb_is_load && wb_addr != 5'd0) m_pend[wb_addr] = 1'b0;
        if (xfer) m_pend[m_out.ad] = 1'b1;
        if (flush) m_ov = 0;
        else if (acc) begin m_out = n; m_ov = 1; end
        else if (out_ready) m_ov = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_pc = '0; in_addr_a = '0; in_addr_b = '0; in_addr_d = '0;
        in_imm = '0; in_imm_sext = 0; in_wb_en = 0; in_mem_r_en = 0; in_mem_w_en = 0;
        in_is_branch = 0; in_is_imm = 0; in_alu_op = '0; flush = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0; wb_is_load = 0; out_ready = 1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic mr, input logic wb);
        in_valid = 1; in_pc = pc; in_addr_a = a; in_addr_b = b; in_addr_d = d;
        in_mem_r_en = mr; in_wb_en = wb; in_imm = '0; in_imm_sext = 0;
        in_mem_w_en = 0; in_is_branch = 0; in_is_imm = 0; in_alu_op = 2'd1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        m_reset();
        set_instr(32'h10, 5'd1, 5'd2, 5'd3, 0, 1);
        #12;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (stall_cnt !== 16'h0) $display("[TB] FAIL reset_stall_cnt: got %h expected 0", stall_cnt); else passes++;
        checks++; if ({out_pc, out_data_a, out_imm} !== 96'h0) $display("[TB] FAIL reset_out_fields: got %h expected 0", {out_pc, out_data_a, out_imm}); else passes++;
        in_valid = 0;
        #1 reset = 1;
        tick();
    endtask

    task automatic test_write_read();
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'h1234;
        tick();
        wb_en = 0;
        set_instr(32'h100, 5'd3, 5'd0, 5'd1, 0, 1);
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL wr_in_ready: got %b expected 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL wr_pre_valid: got %b expected 0", out_valid); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL wr_latency: got %b expected 1", out_valid); else passes++;
        checks++; if (out_data_a !== 32'h1234) $display("[TB] FAIL wr_data_a: got %h expected 00001234", out_data_a); else passes++;
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL wr_bubble_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_data_a !== 32'h1234) $display("[TB] FAIL wr_bubble_retain: got %h expected 00001234", out_data_a); else passes++;
    endtask

    task automatic test_load_use();
        logic [15:0] s0;
        set_instr(32'h300, 5'd0, 5'd0, 5'd5, 1, 1);
        tick();
        set_instr(32'h304, 5'd5, 5'd2, 5'd6, 0, 1);
        s0 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("[TB] FAIL lu_stall_%0d: got %b expected 0", i, in_ready); else passes++;
            tick();
        end
        wb_en = 1; wb_is_load = 1; wb_addr = 5'd5; wb_data = 32'hCAFE;
        #1;
        checks++; if (in_ready !== BYP) $display("[TB] FAIL lu_wb_cycle_ready: got %b expected %b", in_ready, BYP); else passes++;
        tick();
        wb_en = 0; wb_is_load = 0;
`ifndef DECODE_WB_BYPASS_EN
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL lu_extra_cycle_ready: got %b expected 1", in_ready); else passes++;
        tick();
`endif
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304) $display("[TB] FAIL lu_issue: got valid %b pc %h expected 1 00000304", out_valid, out_pc); else passes++;
        checks++; if (out_data_a !== 32'hCAFE) $display("[TB] FAIL lu_data: got %h expected 0000cafe", out_data_a); else passes++;
        checks++; if (stall_cnt !== s0 + (BYP ? 16'd3 : 16'd4)) $display("[TB] FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, s0 + (BYP ? 16'd3 : 16'd4)); else passes++;
        in_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        set_instr(32'h400, 5'd1, 5'd2, 5'd8, 0, 1);
        tick();
        out_ready = 0;
        set_instr(32'h404, 5'd3, 5'd4, 5'd9, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_%0d: got %b expected 0", i, in_ready); else passes++;
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) $display("[TB] FAIL bp_hold_%0d: got valid %b pc %h expected 1 00000400", i, out_valid, out_pc); else passes++;
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h404) $display("[TB] FAIL bp_next: got valid %b pc %h expected 1 00000404", out_valid, out_pc); else passes++;
        in_valid = 0;
        tick();
    endtask

    task automatic test_flush();
        logic [15:0] s0;
        set_instr(32'h500, 5'd0, 5'd0, 5'd7, 1, 1);
        tick();
        flush = 1;
        set_instr(32'h504, 5'd1, 5'd1, 5'd3, 0, 1);
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL fl_ready: got %b expected 1", in_ready); else passes++;
        tick();
        flush = 0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL fl_valid: got %b expected 0", out_valid); else passes++;
        set_instr(32'h508, 5'd7, 5'd7, 5'd4, 0, 1);
        s0 = stall_cnt;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL fl_dep_ready: got %b expected 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h508) $display("[TB] FAIL fl_dep_issue: got valid %b pc %h expected 1 00000508", out_valid, out_pc); else passes++;
        checks++; if (stall_cnt !== s0) $display("[TB] FAIL fl_no_stall: got %0d expected %0d", stall_cnt, s0); else passes++;
        in_valid = 0;
        tick();
    endtask

    task automatic test_imm();
        set_instr(32'h600, 5'd0, 5'd0, 5'd1, 0, 1);
        in_imm = 16'h8001; in_imm_sext = 1; in_is_imm = 1;
        tick();
        checks++; if (out_imm !== 32'hFFFF8001) $display("[TB] FAIL imm_sext: got %h expected ffff8001", out_imm); else passes++;
        in_imm_sext = 0;
        tick();
        checks++; if (out_imm !== 32'h00008001) $display("[TB] FAIL imm_zext: got %h expected 00008001", out_imm); else passes++;
        in_valid = 0;
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
        tick();
        wb_en = 0;
        set_instr(32'h608, 5'd0, 5'd0, 5'd1, 0, 1);
        tick();
        checks++; if (out_data_a !== 32'h0 || out_data_b !== 32'h0) $display("[TB] FAIL r0_read: got %h %h expected 0 0", out_data_a, out_data_b); else passes++;
        in_valid = 0;
        tick();
    endtask

    task automatic test_random();
        out_t exp_o;
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_pc        = $urandom;
            in_addr_a    = 5'($urandom_range(0, 7));
            in_addr_b    = 5'($urandom_range(0, 7));
            in_addr_d    = 5'($urandom_range(0, 7));
            in_imm       = 16'($urandom);
            in_imm_sext  = 1'($urandom_range(0, 1));
            in_wb_en     = 1'($urandom_range(0, 1));
            in_mem_r_en  = 1'($urandom_range(0, 1));
            in_mem_w_en  = 1'($urandom_range(0, 1));
            in_is_branch = 1'($urandom_range(0, 1));
            in_is_imm    = 1'($urandom_range(0, 1));
            in_alu_op    = 2'($urandom_range(0, 3));
            flush        = ($urandom_range(0, 15) == 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            wb_en        = 1'($urandom_range(0, 1));
            wb_addr      = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            wb_is_load   = 1'($urandom_range(0, 1));
            #1;
            checks++; if (in_ready !== m_ready()) $display("[TB] FAIL rnd_ready_%0d: got %b expected %b", i, in_ready, m_ready()); else passes++;
            tick();
            exp_o = m_out;
            checks++;
            if ({out_valid, out_pc, out_data_a, out_data_b, out_imm, out_addr_a, out_addr_b, out_addr_d,
                 out_alu_op, out_wb_en, out_mem_r_en, out_mem_w_en, out_is_branch, out_is_imm}
                !== {m_ov, exp_o})
                $display("[TB] FAIL rnd_out_%0d: got v%b pc %h a %h b %h imm %h expected v%b pc %h a %h b %h imm %h",
                         i, out_valid, out_pc, out_data_a, out_data_b, out_imm,
                         m_ov, exp_o.pc, exp_o.da, exp_o.db, exp_o.imm);
            else passes++;
            checks++; if (stall_cnt !== 16'(m_stall)) $display("[TB] FAIL rnd_stall_%0d: got %0d expected %0d", i, stall_cnt, m_stall); else passes++;
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_instr(32'h700, 5'd0, 5'd0, 5'd9, 1, 1);
        tick();
        set_instr(32'h704, 5'd9, 5'd0, 5'd10, 0, 1);
        tick();
        #1;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL rms_stalled: got %b expected 0", in_ready); else passes++;
        reset = 0;
        m_reset();
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || stall_cnt !== 16'h0) $display("[TB] FAIL rms_in_reset: got ready %b valid %b stall %0d expected 0 0 0", in_ready, out_valid, stall_cnt); else passes++;
        reset = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rms_no_residual: got %b expected 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h704 || out_data_a !== 32'h0) $display("[TB] FAIL rms_issue: got valid %b pc %h a %h expected 1 00000704 0", out_valid, out_pc, out_data_a); else passes++;
        in_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_load_use();
        test_backpressure();
        test_flush();
        test_imm();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
